// File: rtl/decoder32_pkg.sv
// Shared definitions for decoder32 and the blocks that drive its index input.
package decoder32_pkg;
  localparam int N_OUT = 32;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] IDX_MAX = 5'(N_OUT - 1);

  typedef enum logic [1:0] {
    MODE_SINGLE_UP = 2'b00,
    MODE_WRAP      = 2'b01,
    MODE_PINGPONG  = 2'b10,
    MODE_SINGLE_DN = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/decoder32_scan_ctrl_tick_gen.sv
// Programmable step-rate divider: tick is high for one cycle every div_q+1 cycles.
module scan_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_q,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == div_q);

  always_ff @(posedge CLK) begin
    if (RST || clear || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/decoder32_scan_ctrl.sv
// Index sequencer for decoder32: single up/down, wrapping and ping-pong sweeps
// at a programmable hold rate, with START/STOP control and a DONE pulse.
module decoder32_scan_ctrl
  import decoder32_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic [DIV_W-1:0] DIV,
  output logic [IDX_W-1:0] INDEX,
  output logic             VALID,
  output logic             BUSY,
  output logic             DIR,
  output logic             DONE
);
  state_e           state, state_nx;
  mode_e            mode_q, mode_nx;
  logic [DIV_W-1:0] div_q, div_nx;
  logic [IDX_W-1:0] index_nx;
  logic             dir_nx, done_nx, tick;

  // Divider is held at zero outside RUN so every sweep starts on a full period.
  scan_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .CLK   (CLK),
    .RST   (RST),
    .clear (state != ST_RUN),
    .div_q (div_q),
    .tick  (tick)
  );

  assign VALID = (state == ST_RUN);
  assign BUSY  = VALID;

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    div_nx   = div_q;
    index_nx = INDEX;
    dir_nx   = DIR;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START && !STOP) begin
          state_nx = ST_RUN;
          mode_nx  = mode_e'(MODE);
          div_nx   = DIV;
          if (mode_e'(MODE) == MODE_SINGLE_DN) begin
            index_nx = IDX_MAX;
            dir_nx   = 1'b1;
          end else begin
            index_nx = '0;
            dir_nx   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          case (mode_q)
            MODE_SINGLE_UP: begin
              if (INDEX == IDX_MAX) begin
                state_nx = ST_IDLE;
                done_nx  = 1'b1;
              end else index_nx = INDEX + 1'b1;
            end
            MODE_SINGLE_DN: begin
              if (INDEX == '0) begin
                state_nx = ST_IDLE;
                done_nx  = 1'b1;
              end else index_nx = INDEX - 1'b1;
            end
            MODE_WRAP: index_nx = INDEX + 1'b1;
            MODE_PINGPONG: begin
              // Turn around immediately so endpoints are shown for one period only.
              if (!DIR) begin
                if (INDEX == IDX_MAX) begin
                  dir_nx   = 1'b1;
                  index_nx = IDX_MAX - 1'b1;
                end else index_nx = INDEX + 1'b1;
              end else begin
                if (INDEX == '0) begin
                  dir_nx   = 1'b0;
                  index_nx = 5'd1;
                end else index_nx = INDEX - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      mode_q <= MODE_SINGLE_UP;
      div_q  <= '0;
      INDEX  <= '0;
      DIR    <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nx;
      mode_q <= mode_nx;
      div_q  <= div_nx;
      INDEX  <= index_nx;
      DIR    <= dir_nx;
      DONE   <= done_nx;
    end
  end
endmodule

// File: doc/decoder32_scan_ctrl.md
Name: decoder32_scan_ctrl

Overview:
Sequencer that sits directly upstream of decoder32 and drives its 5-bit INPUT.
- Steps a 5-bit index across all 32 positions at a programmable rate.
- Supports single up, single down, continuous wrap and ping-pong sweeps.
- START/STOP control with BUSY and VALID status and a DONE pulse at the end of a single sweep.
- INDEX connects straight to decoder32.INPUT; VALID qualifies decoder32.OUTPUT downstream.

Parameters:
DIV_W, 16, width of the step-rate divider; each index is held DIV+1 cycles.

Ports:
CLK  input  1  single clock; all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  level-sampled; accepted only in IDLE.
STOP  input  1  aborts a sweep; wins over START in the same cycle.
MODE  input  2  00 single up, 01 continuous up (wrap), 10 ping-pong continuous, 11 single down.
DIV  input  DIV_W  hold length minus one per index; captured at START.
INDEX  output  5  current index; drives decoder32.INPUT.
VALID  output  1  INDEX is part of an active sweep.
BUSY  output  1  sweep in progress.
DIR  output  1  0 = counting up, 1 = counting down.
DONE  output  1  one-cycle pulse when a single-sweep mode completes.

Behaviour:
- Reset (RST=1 at an edge): INDEX=0, VALID=0, BUSY=0, DIR=0, DONE=0, divider=0, state=IDLE. RST overrides every other input.
- States:
  - IDLE: waits for start.
  - RUN: sweep in progress.
  - There is no separate done state; DONE is a registered pulse issued on the transition RUN->IDLE.
- IDLE, START=1, STOP=0: capture MODE and DIV into shadow registers; go to RUN. On the next cycle:
  - VALID=1, BUSY=1, divider=0.
  - INDEX=31 and DIR=1 for MODE=11.
  - INDEX=0 and DIR=0 otherwise.
- Latency: START sampled at edge k gives the first INDEX visible after edge k.
- RUN: the divider counts 0..DIV_q. A step occurs when the divider equals DIV_q; the divider then returns to 0. With DIV=0 the index steps every cycle.
- Step rules:
  - 00: INDEX+1; at 31 the step ends the sweep instead.
  - 11: INDEX-1; at 0 the step ends the sweep.
  - 01: INDEX+1, wrapping 31->0; never ends.
  - 10: up to 31, then DIR=1 and the next index is 30; down to 0, then DIR=0 and the next index is 1. Endpoints are held for one period only, never doubled.
- Sweep end (modes 00/11): next cycle state=IDLE, VALID=0, BUSY=0, DONE=1 for exactly one cycle. INDEX holds its last value (31 or 0).
- STOP=1 in RUN: next cycle state=IDLE, VALID=0, BUSY=0, DONE stays 0, INDEX and DIR hold.
- Ignored inputs:
  - START while in RUN.
  - MODE and DIV changes while in RUN; shadow registers only.
- START in the cycle DONE=1 is accepted, since the state is already IDLE.
- RST mid-sweep: all outputs return to reset values on the next edge; no DONE pulse.
- Widths: INDEX arithmetic is 5-bit modulo 32 and is used only in mode 01. The divider is DIV_W bits, compared for equality only.

Decomposition:
- Shared package decoder32_pkg:
  - localparams N_OUT=32 and IDX_W=5.
  - MODE encodings MODE_SINGLE_UP, MODE_WRAP, MODE_PINGPONG, MODE_SINGLE_DN.
  - State encodings ST_IDLE, ST_RUN.
- Sub-module scan_tick_gen:
  - Takes CLK, RST, clear and DIV_q; emits a one-cycle TICK when the count reaches DIV_q.
  - Reused by later display-scan blocks.

Test Plan:
- Reset: hold RST=1 for 2 cycles with START=1 -> INDEX=0, VALID=0, BUSY=0, DONE=0, DIR=0 throughout; no sweep starts.
- MODE=00, DIV=0, START pulse -> INDEX 0,1,...,31 on consecutive cycles with VALID=1 for 32 cycles. DONE=1 on cycle 33 only, VALID=0 and INDEX=31 after. The decoder32 output walks one-hot bit 0..31.
- MODE=11, DIV=3 -> INDEX 31 down to 0, each held 4 cycles (128 VALID cycles), DIR=1, single DONE pulse. Changing DIV to 0 mid-sweep has no effect.
- MODE=10, DIV=0 -> INDEX sequence 0..31,30..0,1..; DIR toggles on the cycle INDEX becomes 30 and on the cycle it becomes 1. STOP at cycle 70 -> VALID=0 and BUSY=0 next cycle, DONE=0, INDEX held.
- MODE=01, DIV=1 -> INDEX 31 followed by 0, each held 2 cycles, no DONE. RST asserted when INDEX=17 -> reset values on the next edge.
- In IDLE, assert START=1 and STOP=1 together -> stays IDLE with VALID=0. START during RUN -> sweep unaffected. START in the DONE cycle -> new sweep begins next cycle at INDEX=0.
